id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline register between the decode stage, where instruction fields are split and the control decoder runs, and the execute stage. It captures the decoder's EX/MEM/WB control fields together with the operand data of the instruction in ID. It also detects load-use hazards, requests an IF/ID hold, and inserts a bubble. A taken branch or jump resolved in EX flushes the wrong-path instruction.

## Interface
- No parameters. Widths are fixed by the 32-bit MIPS datapath.
- `clk`  in  1  — single clock; all state updates on rising edge.
- `reset`  in  1  — synchronous, active-high.
- `id_ALUOp`  in  4  — ALU operation code from the control decoder.
- `id_ALUSrc1`, `id_ALUSrc2`  in  1 each  — ALU operand select.
- `id_RegDst`  in  2  — destination select: 00 rt, 01 rd, 10 $31.
- `id_MemRead`, `id_MemWrite`  in  1 each  — data memory control.
- `id_MemtoReg`  in  2  — writeback select: 00 ALU, 01 memory, 10 PC+4.
- `id_RegWrite`, `id_Branch`  in  1 each.
- `id_pc_plus4`, `id_rs_data`, `id_rt_data`, `id_imm_ext`  in  32 each.
- `id_rs`, `id_rt`, `id_rd`, `id_shamt`  in  5 each.
- `flush`  in  1  — taken branch or jump resolved this cycle; the ID instruction is wrong-path.
- `ex_*`  out  —  registered copy of every `id_*` input, same name and width.
- `stall_if_id`  out  1  — combinational. Holds the PC and the IF/ID register this cycle.
- `bubble_count`  out  32  — number of bubbles inserted (see Configuration).

## Operation
- Per-edge priority is `reset` > `flush` > load-use > normal capture.
- **reset:** every `ex_*` output goes to 0. This is a bubble: RegWrite, MemRead, MemWrite and Branch are all 0.
- **flush:** load a bubble. All control fields are 0 and all data fields are 0.
- **load-use:** `load_use = ex_MemRead & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt))`.
  - Load a bubble, same as flush.
  - Assert `stall_if_id` so the same ID instruction is re-presented next cycle.
- **normal:** capture all `id_*` into `ex_*`.
- `stall_if_id = load_use & ~flush & ~reset`.
  - A flush overrides a stall, so the branch target is allowed to load into the PC.
- A second load-use cannot occur back-to-back for the same instruction, because the bubble clears `ex_MemRead`. The stall therefore lasts exactly 1 cycle.
- `$0` is never a hazard source: an `ex_rt` of 0 is ignored.
- No operand forwarding is performed here; the EX forwarding unit consumes `ex_rs`/`ex_rt`.

## Timing
- Latency is 1 cycle, ID to EX.
- `stall_if_id` is valid in the same cycle as the ID inputs. It depends only on current `ex_*` registers and `id_rs`/`id_rt`.
- Load followed by a dependent instruction gives exactly one bubble cycle. The dependent instruction reaches EX 2 cycles after the load.
- `flush` asserted alongside a hazard gives a bubble with `stall_if_id` = 0.
- Reset asserted mid-stall: on the next edge the outputs are 0 and `stall_if_id` is 0 while `reset` is high.

## Configuration
- `ID_EX_BUBBLE_CNT_EN` defined:
  - `bubble_count` increments by 1 on each edge where a bubble is loaded because of flush or load-use, excluding reset.
  - It saturates at 32'hFFFF_FFFF.
  - Reset clears it to 0.
- `ID_EX_BUBBLE_CNT_EN` undefined: `bubble_count` is tied to 0 and no counter register exists. The port list is unchanged.

## Structure
- The shared package holds:
  - encodings for `RegDst` and `MemtoReg`;
  - the ALUOp width;
  - a single EX-control bundle constant `CTRL_BUBBLE` (all zero) used by both flush and load-use paths.
- One sub-module, `load_use_detect`: purely combinational. Inputs are `ex_MemRead`, `ex_rt`, `id_rs`, `id_rt`; output is `load_use`.
- The register and counter live in the top module.

## Test plan
- **Reset:** hold `reset` 2 cycles with random `id_*` inputs → all `ex_*` = 0, `stall_if_id` = 0, `bubble_count` = 0.
- **Normal capture:** `id_ALUOp` = 4'b0010, `id_RegWrite` = 1, `id_rs_data` = 32'h1234_5678 → next edge `ex_ALUOp` = 4'b0010, `ex_rs_data` = 32'h1234_5678, `stall_if_id` = 0.
- **Load-use:** `lw $8` in EX (`ex_MemRead` = 1, `ex_rt` = 8), `add` in ID with `id_rs` = 8 → `stall_if_id` = 1 for one cycle; next edge `ex_RegWrite` = 0 and `ex_MemRead` = 0; following edge the `add` fields are captured; count = 1.
- **$0 exemption:** `ex_MemRead` = 1, `ex_rt` = 0, `id_rs` = 0 → no stall, normal capture.
- **Flush during hazard:** `flush` = 1 together with the load-use condition above → `stall_if_id` = 0; next edge bubble; count +1 (not +2).
- **Saturation** (macro on): force the counter to 32'hFFFF_FFFE, then two flushes → 32'hFFFF_FFFF, stays there. With the macro off the same sequence → `bubble_count` = 0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared encodings and EX-control bundle for the ID/EX pipeline register.
package id_ex_stage_pkg;

    localparam int ALUOP_W = 4;

    typedef enum logic [1:0] {
        REGDST_RT = 2'b00,
        REGDST_RD = 2'b01,
        REGDST_RA = 2'b10
    } regdst_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } memtoreg_e;

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src1;
        logic               alu_src2;
        logic [1:0]         reg_dst;
        logic               mem_read;
        logic               mem_write;
        logic [1:0]         mem_to_reg;
        logic               reg_write;
        logic               branch;
    } ex_ctrl_t;

    typedef struct packed {
        ex_ctrl_t    ctrl;
        logic [31:0] pc_plus4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm_ext;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
    } ex_reg_t;

    localparam ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the register a load in EX is writing.
module load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic       ex_MemRead,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       load_use
);

    assign load_use = ex_MemRead & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush bubbles and an optional
// bubble counter enabled by ID_EX_BUBBLE_CNT_EN.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [ALUOP_W-1:0] id_ALUOp,
    input  logic               id_ALUSrc1,
    input  logic               id_ALUSrc2,
    input  logic [1:0]         id_RegDst,
    input  logic               id_MemRead,
    input  logic               id_MemWrite,
    input  logic [1:0]         id_MemtoReg,
    input  logic               id_RegWrite,
    input  logic               id_Branch,
    input  logic [31:0]        id_pc_plus4,
    input  logic [31:0]        id_rs_data,
    input  logic [31:0]        id_rt_data,
    input  logic [31:0]        id_imm_ext,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic [4:0]         id_rd,
    input  logic [4:0]         id_shamt,
    input  logic               flush,
    output logic [ALUOP_W-1:0] ex_ALUOp,
    output logic               ex_ALUSrc1,
    output logic               ex_ALUSrc2,
    output logic [1:0]         ex_RegDst,
    output logic               ex_MemRead,
    output logic               ex_MemWrite,
    output logic [1:0]         ex_MemtoReg,
    output logic               ex_RegWrite,
    output logic               ex_Branch,
    output logic [31:0]        ex_pc_plus4,
    output logic [31:0]        ex_rs_data,
    output logic [31:0]        ex_rt_data,
    output logic [31:0]        ex_imm_ext,
    output logic [4:0]         ex_rs,
    output logic [4:0]         ex_rt,
    output logic [4:0]         ex_rd,
    output logic [4:0]         ex_shamt,
    output logic               stall_if_id,
    output logic [31:0]        bubble_count
);

    ex_reg_t ex_d, ex_q, id_bundle, bubble;
    logic    load_use, insert_bubble;

    load_use_detect u_lud (
        .ex_MemRead (ex_q.ctrl.mem_read),
        .ex_rt      (ex_q.rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .load_use   (load_use)
    );

    assign id_bundle = {id_ALUOp, id_ALUSrc1, id_ALUSrc2, id_RegDst, id_MemRead, id_MemWrite,
                        id_MemtoReg, id_RegWrite, id_Branch, id_pc_plus4, id_rs_data, id_rt_data,
                        id_imm_ext, id_rs, id_rt, id_rd, id_shamt};
    assign bubble        = {CTRL_BUBBLE, {($bits(ex_reg_t) - $bits(ex_ctrl_t)){1'b0}}};
    assign insert_bubble = flush | load_use;
    assign ex_d          = insert_bubble ? bubble : id_bundle;
    // a flush wins over the stall so the branch target can load into the PC
    assign stall_if_id   = load_use & ~flush & ~reset;

    always_ff @(posedge clk) begin
        if (reset) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    assign ex_ALUOp    = ex_q.ctrl.alu_op;
    assign ex_ALUSrc1  = ex_q.ctrl.alu_src1;
    assign ex_ALUSrc2  = ex_q.ctrl.alu_src2;
    assign ex_RegDst   = ex_q.ctrl.reg_dst;
    assign ex_MemRead  = ex_q.ctrl.mem_read;
    assign ex_MemWrite = ex_q.ctrl.mem_write;
    assign ex_MemtoReg = ex_q.ctrl.mem_to_reg;
    assign ex_RegWrite = ex_q.ctrl.reg_write;
    assign ex_Branch   = ex_q.ctrl.branch;
    assign ex_pc_plus4 = ex_q.pc_plus4;
    assign ex_rs_data  = ex_q.rs_data;
    assign ex_rt_data  = ex_q.rt_data;
    assign ex_imm_ext  = ex_q.imm_ext;
    assign ex_rs       = ex_q.rs;
    assign ex_rt       = ex_q.rt;
    assign ex_rd       = ex_q.rd;
    assign ex_shamt    = ex_q.shamt;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_d, bubble_cnt_q;

    assign bubble_cnt_d = (insert_bubble && bubble_cnt_q != '1) ? bubble_cnt_q + 32'd1 : bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) bubble_cnt_q <= '0;
        else       bubble_cnt_q <= bubble_cnt_d;
    end

    assign bubble_count = bubble_cnt_q;
`else
    assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage; follows ID_EX_BUBBLE_CNT_EN.
module tb_id_ex_stage;

`ifdef ID_EX_BUBBLE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  id_ALUOp;
    logic        id_ALUSrc1, id_ALUSrc2;
    logic [1:0]  id_RegDst;
    logic        id_MemRead, id_MemWrite;
    logic [1:0]  id_MemtoReg;
    logic        id_RegWrite, id_Branch;
    logic [31:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic        flush;
    logic [3:0]  ex_ALUOp;
    logic        ex_ALUSrc1, ex_ALUSrc2;
    logic [1:0]  ex_RegDst;
    logic        ex_MemRead, ex_MemWrite;
    logic [1:0]  ex_MemtoReg;
    logic        ex_RegWrite, ex_Branch;
    logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
    logic        stall_if_id;
    logic [31:0] bubble_count;

    int total = 0;
    int bad   = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .id_ALUOp(id_ALUOp), .id_ALUSrc1(id_ALUSrc1), .id_ALUSrc2(id_ALUSrc2),
        .id_RegDst(id_RegDst), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .id_MemtoReg(id_MemtoReg), .id_RegWrite(id_RegWrite), .id_Branch(id_Branch),
        .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm_ext(id_imm_ext), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_shamt(id_shamt), .flush(flush),
        .ex_ALUOp(ex_ALUOp), .ex_ALUSrc1(ex_ALUSrc1), .ex_ALUSrc2(ex_ALUSrc2),
        .ex_RegDst(ex_RegDst), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite), .ex_Branch(ex_Branch),
        .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm_ext(ex_imm_ext), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_shamt(ex_shamt), .stall_if_id(stall_if_id), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        {id_ALUOp, id_ALUSrc1, id_ALUSrc2, id_RegDst, id_MemRead, id_MemWrite, id_MemtoReg,
         id_RegWrite, id_Branch} = '0;
        {id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext} = '0;
        {id_rs, id_rt, id_rd, id_shamt} = '0;
        flush = 1'b0;
    endtask

    // lw $rt, 0($3)
    task automatic load(input logic [4:0] rt);
        nop();
        id_MemRead = 1'b1; id_MemtoReg = 2'b01; id_RegWrite = 1'b1; id_ALUSrc2 = 1'b1;
        id_rs = 5'd3; id_rt = rt; id_pc_plus4 = 32'h0000_0104;
    endtask

    // add $rd, $rs, $rt
    task automatic add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        nop();
        id_ALUOp = 4'b0010; id_RegWrite = 1'b1; id_RegDst = 2'b01;
        id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = 32'hAAAA_0001; id_pc_plus4 = 32'h0000_0108;
    endtask

    function automatic logic [31:0] any_ex();
        return ex_pc_plus4 | ex_rs_data | ex_rt_data | ex_imm_ext |
               {ex_ALUOp, ex_ALUSrc1, ex_ALUSrc2, ex_RegDst, ex_MemRead, ex_MemWrite, ex_MemtoReg,
                ex_RegWrite, ex_Branch, ex_rs, ex_rt, ex_rd, ex_shamt};
    endfunction

    initial begin
        // reset with random ID inputs
        reset = 1'b1;
        nop();
        {id_ALUOp, id_RegDst, id_MemtoReg} = 8'($urandom);
        {id_ALUSrc1, id_ALUSrc2, id_MemRead, id_MemWrite, id_RegWrite, id_Branch} = 6'($urandom);
        id_pc_plus4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm_ext = $urandom;
        {id_rs, id_rt, id_rd, id_shamt} = 20'($urandom);
        step(); step();
        chk("reset_ex_zero", any_ex(), 32'd0);
        chk("reset_stall", {31'd0, stall_if_id}, 32'd0);
        chk("reset_count", bubble_count, 32'd0);
        reset = 1'b0;

        // normal capture
        nop();
        id_ALUOp = 4'b0010; id_RegWrite = 1'b1; id_rs_data = 32'h1234_5678; id_rs = 5'd1; id_rt = 5'd2;
        id_rt_data = 32'h0BAD_F00D; id_shamt = 5'd7;
        step();
        chk("norm_aluop", {28'd0, ex_ALUOp}, 32'd2);
        chk("norm_rs_data", ex_rs_data, 32'h1234_5678);
        chk("norm_rt_data", ex_rt_data, 32'h0BAD_F00D);
        chk("norm_regwrite", {31'd0, ex_RegWrite}, 32'd1);
        chk("norm_shamt", {27'd0, ex_shamt}, 32'd7);
        chk("norm_stall", {31'd0, stall_if_id}, 32'd0);

        // load-use: one bubble, then the add is captured
        load(5'd8);
        step();
        chk("lu_load_memread", {31'd0, ex_MemRead}, 32'd1);
        add(5'd8, 5'd9, 5'd10);
        #1;
        chk("lu_stall", {31'd0, stall_if_id}, 32'd1);
        step();
        chk("lu_bubble_regwrite", {31'd0, ex_RegWrite}, 32'd0);
        chk("lu_bubble_memread", {31'd0, ex_MemRead}, 32'd0);
        chk("lu_bubble_all", any_ex(), 32'd0);
        chk("lu_stall_released", {31'd0, stall_if_id}, 32'd0);
        chk("lu_count", bubble_count, CNT_ON ? 32'd1 : 32'd0);
        step();
        chk("lu_add_rd", {27'd0, ex_rd}, 32'd10);
        chk("lu_add_rs", {27'd0, ex_rs}, 32'd8);
        chk("lu_add_regwrite", {31'd0, ex_RegWrite}, 32'd1);
        chk("lu_add_rs_data", ex_rs_data, 32'hAAAA_0001);

        // $0 is never a hazard source
        load(5'd0);
        step();
        add(5'd0, 5'd5, 5'd6);
        #1;
        chk("zero_stall", {31'd0, stall_if_id}, 32'd0);
        step();
        chk("zero_capture_rd", {27'd0, ex_rd}, 32'd6);
        chk("zero_count", bubble_count, CNT_ON ? 32'd1 : 32'd0);

        // rt-operand hazard
        load(5'd12);
        step();
        add(5'd4, 5'd12, 5'd13);
        #1;
        chk("rt_hazard_stall", {31'd0, stall_if_id}, 32'd1);

        // flush together with a hazard: bubble, no stall, one count
        flush = 1'b1;
        #1;
        chk("flush_stall", {31'd0, stall_if_id}, 32'd0);
        step();
        chk("flush_bubble", any_ex(), 32'd0);
        chk("flush_count", bubble_count, CNT_ON ? 32'd2 : 32'd0);
        flush = 1'b0;
        #1;
        chk("flush_after_stall", {31'd0, stall_if_id}, 32'd0);

        // reset mid-stall
        load(5'd8);
        step();
        add(5'd8, 5'd1, 5'd2);
        #1;
        chk("rst_pre_stall", {31'd0, stall_if_id}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_stall_masked", {31'd0, stall_if_id}, 32'd0);
        step();
        chk("rst_ex_zero", any_ex(), 32'd0);
        chk("rst_count", bubble_count, 32'd0);
        reset = 1'b0;
        nop();

        // saturation
`ifdef ID_EX_BUBBLE_CNT_EN
        force dut.bubble_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.bubble_cnt_q;
`endif
        flush = 1'b1;
        step();
        chk("sat_first", bubble_count, CNT_ON ? 32'hFFFF_FFFF : 32'd0);
        step();
        chk("sat_hold", bubble_count, CNT_ON ? 32'hFFFF_FFFF : 32'd0);
        flush = 1'b0;
        step();
        chk("sat_idle", bubble_count, CNT_ON ? 32'hFFFF_FFFF : 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
